// File: rtl/dual_fa_bist_if.sv
// rtl/dual_fa_bist_if.sv - stimulus, response and start/done bundle of the dual full-adder BIST
interface dual_fa_bist_if;
    logic       start;
    logic       a, b, c, d, e, f;
    logic       s1, cout1, s2, cout2;
    logic       busy;
    logic       done;
    logic       pass;
    logic [6:0] err_count;
    logic [5:0] first_fail;

    // master is the BIST controller; slave is the adder block plus the host issuing start
    modport master (
        input  start, s1, cout1, s2, cout2,
        output a, b, c, d, e, f, busy, done, pass, err_count, first_fail
    );

    modport slave (
        output start, s1, cout1, s2, cout2,
        input  a, b, c, d, e, f, busy, done, pass, err_count, first_fail
    );
endinterface

// File: rtl/dual_fa_bist.sv
// rtl/dual_fa_bist.sv - exhaustive 64-vector self-test sweep of a dual full-adder block
module dual_fa_bist #(
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    dual_fa_bist_if.master    bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [2:0] C_SETTLE = 3'(SETTLE);

    state_t     r_state;
    logic [5:0] r_v;
    logic [2:0] r_cnt;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [6:0] r_err;
    logic [5:0] r_first;

    logic       w_exp_s1, w_exp_cout1, w_exp_s2, w_exp_cout2;
    logic       w_mismatch;
    logic [6:0] w_err_next;

    // v = {a,b,c,d,e,f}: first adder on v[5:3], second on v[2:0]
    assign w_exp_s1    = r_v[5] ^ r_v[4] ^ r_v[3];
    assign w_exp_cout1 = (r_v[5] & r_v[4]) | (r_v[5] & r_v[3]) | (r_v[4] & r_v[3]);
    assign w_exp_s2    = r_v[2] ^ r_v[1] ^ r_v[0];
    assign w_exp_cout2 = (r_v[2] & r_v[1]) | (r_v[2] & r_v[0]) | (r_v[1] & r_v[0]);

    assign w_mismatch = (bus.s1 != w_exp_s1) | (bus.cout1 != w_exp_cout1) |
                        (bus.s2 != w_exp_s2) | (bus.cout2 != w_exp_cout2);
    assign w_err_next = w_mismatch ? (r_err + 7'd1) : r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_v     <= 6'd0;
            r_cnt   <= 3'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= 7'd0;
            r_first <= 6'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_v     <= 6'd0;
                        r_err   <= 7'd0;
                        r_first <= 6'd0;
                        r_pass  <= 1'b0;
                        r_cnt   <= C_SETTLE;
                        r_busy  <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 3'd1) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_CHECK: begin
                    if (w_mismatch) begin
                        r_err <= w_err_next;
                        if (r_err == 7'd0) begin
                            r_first <= r_v;
                        end
                    end
                    // done and the verdict are registered here so they appear in the DONE cycle
                    if (r_v == 6'd63) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == 7'd0);
                        r_state <= S_DONE;
                    end else begin
                        r_v     <= r_v + 6'd1;
                        r_cnt   <= C_SETTLE;
                        r_state <= S_WAIT;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f} = r_v;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.pass       = r_pass;
    assign bus.err_count  = r_err;
    assign bus.first_fail = r_first;
endmodule
